// File: rtl/dmem_resp.sv
// Word-organised data RAM with byte lanes: aligns stores, extends loads, flags illegal accesses.
// One response exactly 1 cycle after acceptance; accepts a request only in IDLE, so throughput is one per 2 cycles.
module dmem_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_wea,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic [15:0] acc_cnt
);

  localparam int   DEPTH = 1 << DEPTH_LOG2;
  localparam logic IDLE  = 1'b0;
  localparam logic RESP  = 1'b1;

  logic                  state;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rel;
  logic [1:0]            off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  err;
  logic                  accept;
  logic [3:0]            be;
  logic [31:0]           wshift;
  logic [31:0]           word;
  logic [31:0]           field;
  logic [31:0]           rdata_ext;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  always_comb begin
    rel      = req_addr - BASE_ADDR;
    off      = req_addr[1:0];
    idx      = rel[DEPTH_LOG2+1:2];
    in_range = (rel >> (DEPTH_LOG2 + 2)) == 32'd0;
    be       = req_wea << off;
    wshift   = req_wdata << {off, 3'b000};
    word     = mem[idx];
    field    = word >> {off, 3'b000};
  end

  always_comb begin
    err = 1'b0;
    if (req_we) begin
      case (req_wea)
        4'b1111: err = (off != 2'd0);
        4'b0011: err = off[0];
        4'b0001: err = 1'b0;
        default: err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: err = 1'b0;
        3'b001, 3'b101: err = off[0];
        3'b010:         err = (off != 2'd0);
        default:        err = 1'b1;
      endcase
    end
    if (!in_range) err = 1'b1;
  end

  always_comb begin
    rdata_ext = 32'd0;
    case (req_funct3)
      3'b000:  rdata_ext = {{24{field[7]}}, field[7:0]};
      3'b001:  rdata_ext = {{16{field[15]}}, field[15:0]};
      3'b010:  rdata_ext = word;
      3'b100:  rdata_ext = {24'd0, field[7:0]};
      3'b101:  rdata_ext = {16'd0, field[15:0]};
      default: rdata_ext = 32'd0;
    endcase
  end

  // Loads hold the pipeline in IDLE as well, until their data is returned.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    accept    = req_valid & req_ready;
    stall     = (req_valid & ~req_ready) | (req_valid & ~req_we & req_ready);
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      acc_cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? 32'd0 : rdata_ext;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          if (!rsp_err) acc_cnt <= acc_cnt + 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: stores, loads, lane alignment, error cases, back-to-back loads and reset mid-response.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wea;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic [15:0] acc_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dmem_resp #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wea(req_wea), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall(stall), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and check its single response.
  task automatic req(input string tag, input logic we, input logic [3:0] wea,
                     input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    req_valid  = 1'b1;
    req_we     = we;
    req_wea    = wea;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'(!we));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    req_wea   = 4'b1111;
    #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".ready_resp"}, 32'(req_ready), 32'd0);
    chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp [4];

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wea = 4'd0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err", 32'(rsp_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.acc_cnt", 32'(acc_cnt), 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    req("sw10", 1'b1, 4'b1111, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    req("lw10", 1'b0, 4'b0000, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    chk("cnt2", 32'(acc_cnt), 32'd2);

    req("sw10b", 1'b1, 4'b1111, 3'b010, 32'h10, 32'h11223344, 32'd0, 1'b0);
    req("sb13", 1'b1, 4'b0001, 3'b000, 32'h13, 32'h000000A5, 32'd0, 1'b0);
    req("lw10b", 1'b0, 4'b0000, 3'b010, 32'h10, 32'd0, 32'hA5223344, 1'b0);
    req("lb13", 1'b0, 4'b0000, 3'b000, 32'h13, 32'd0, 32'hFFFFFFA5, 1'b0);
    req("lbu13", 1'b0, 4'b0000, 3'b100, 32'h13, 32'd0, 32'h000000A5, 1'b0);

    req("sw20", 1'b1, 4'b1111, 3'b010, 32'h20, 32'h12345678, 32'd0, 1'b0);
    req("sh22", 1'b1, 4'b0011, 3'b001, 32'h22, 32'h00008001, 32'd0, 1'b0);
    req("lh22", 1'b0, 4'b0000, 3'b001, 32'h22, 32'd0, 32'hFFFF8001, 1'b0);
    req("lhu22", 1'b0, 4'b0000, 3'b101, 32'h22, 32'd0, 32'h00008001, 1'b0);
    req("lhu20", 1'b0, 4'b0000, 3'b101, 32'h20, 32'd0, 32'h00005678, 1'b0);
    req("lw20", 1'b0, 4'b0000, 3'b010, 32'h20, 32'd0, 32'h80015678, 1'b0);
    chk("cnt13", 32'(acc_cnt), 32'd13);

    req("e_lw11", 1'b0, 4'b0000, 3'b010, 32'h11, 32'd0, 32'd0, 1'b1);
    req("e_sh21", 1'b1, 4'b0011, 3'b001, 32'h21, 32'hFFFFFFFF, 32'd0, 1'b1);
    req("e_wea7", 1'b1, 4'b0111, 3'b010, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b1);
    req("e_f3_3", 1'b0, 4'b0000, 3'b011, 32'h20, 32'd0, 32'd0, 1'b1);
    req("e_lw_oor", 1'b0, 4'b0000, 3'b010, 32'h1000, 32'd0, 32'd0, 1'b1);
    req("e_sw_oor", 1'b1, 4'b1111, 3'b010, 32'h1010, 32'hFFFFFFFF, 32'd0, 1'b1);
    chk("cnt_err", 32'(acc_cnt), 32'd13);
    req("lw20_keep", 1'b0, 4'b0000, 3'b010, 32'h20, 32'd0, 32'h80015678, 1'b0);
    req("lw10_keep", 1'b0, 4'b0000, 3'b010, 32'h10, 32'd0, 32'hA5223344, 1'b0);
    chk("cnt15", 32'(acc_cnt), 32'd15);

    // Four loads with req_valid held high.
    b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hA5223344;
    b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h80015678;
    b2b_addr[2] = 32'h10; b2b_exp[2] = 32'hA5223344;
    b2b_addr[3] = 32'h20; b2b_exp[3] = 32'h80015678;
    pulses = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      req_addr = b2b_addr[i];
      #1;
      chk("b2b.ready_idle", 32'(req_ready), 32'd1);
      chk("b2b.stall_idle", 32'(stall), 32'd1);
      @(posedge clk); #1;
      req_addr = 32'h40;
      #1;
      chk("b2b.ready_resp", 32'(req_ready), 32'd0);
      chk("b2b.stall_resp", 32'(stall), 32'd1);
      if (rsp_valid) pulses++;
      chk("b2b.rdata", rsp_rdata, b2b_exp[i]);
      if (i == 3) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b.pulses", 32'(pulses), 32'd4);
    chk("b2b.idle", 32'(rsp_valid), 32'd0);
    chk("cnt19", 32'(acc_cnt), 32'd19);

    // Reset while a store response is pending.
    req_valid = 1'b1; req_we = 1'b1; req_wea = 4'b1111; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid.rst_ready", 32'(req_ready), 32'd1);
    chk("mid.rst_cnt", 32'(acc_cnt), 32'd0);
    @(negedge clk) rstn = 1'b1;
    req("lw30", 1'b0, 4'b0000, 3'b010, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0);
    chk("cnt_after_rst", 32'(acc_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
